// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-master bus: arbiter state encoding, the slave
// select codes every master and slave decodes against, and the owner-selection
// rule used whenever the bus is free.
// -----------------------------------------------------------------------------
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT1 = 2'd1,
      GNT2 = 2'd2,
      TURN = 2'd3
   } arb_state_t;

   localparam logic [2:0] SLV1 = 3'b001;
   localparam logic [2:0] SLV2 = 3'b010;

   // Pick the next owner of a free bus. On contention the master that did not
   // own the bus last wins, which gives round-robin fairness.
   function automatic arb_state_t pick_owner(input logic req_1,
                                             input logic req_2,
                                             input logic last_was_2);
      arb_state_t nxt;
      if (req_1 && req_2) begin
         nxt = last_was_2 ? GNT1 : GNT2;
      end else if (req_1) begin
         nxt = GNT1;
      end else if (req_2) begin
         nxt = GNT2;
      end else begin
         nxt = IDLE;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bus_slave_decode.sv
// -----------------------------------------------------------------------------
// bus_slave_decode
// Combinational slave-select decoder for the bus owner.
// Ports:
//   sel     in   SEL_W  owner's slave select
//   rw      in   1      owner's direction (1 = write)
//   en      out  2      one-hot slave enable (bit0 = slave 1, bit1 = slave 2)
//   err     out  1      select does not map to any slave
//   rw_out  out  1      direction passed through to the bus
// -----------------------------------------------------------------------------
module bus_slave_decode
   import bus_pkg::*;
#(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             rw,
   output logic [1:0]       en,
   output logic             err,
   output logic             rw_out
);

   // Map the select code onto a slave enable; unknown codes flag an error.
   always_comb begin
      en     = 2'b00;
      err    = 1'b0;
      rw_out = rw;
      case (sel)
         SEL_W'(SLV1): en  = 2'b01;
         SEL_W'(SLV2): en  = 2'b10;
         default:      err = 1'b1;
      endcase
   end

endmodule

// File: rtl/bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2m
// Arbiter for a bus shared by two masters. Round-robin on contention, bounded
// tenure when the other master is waiting, and a dead cycle (TURN) at every
// change of owner. All outputs are registered one stage behind the state, so a
// request seen in IDLE produces a grant two edges later.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   busreq_1/2            bus requests, held high for the whole transfer
//   rw_1/2                master direction (1 = write)
//   sel_1/2               master slave select
//   grant_1/2             bus grants
//   slave_en              one-hot slave enable of the current owner
//   bus_rw                owner's direction, 1 when idle
//   bus_busy              high while either grant is high
//   decode_err            owner selected an unmapped slave
// -----------------------------------------------------------------------------
module bus_arbiter_2m
   import bus_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter int MAX_TENURE = 16,
   parameter int CNT_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             busreq_1,
   input  logic             busreq_2,
   input  logic             rw_1,
   input  logic             rw_2,
   input  logic [SEL_W-1:0] sel_1,
   input  logic [SEL_W-1:0] sel_2,
   output logic             grant_1,
   output logic             grant_2,
   output logic [1:0]       slave_en,
   output logic             bus_rw,
   output logic             bus_busy,
   output logic             decode_err
);

   arb_state_t       state_r;
   arb_state_t       next_state_s;
   logic             last_owner_r;   // 1 = master 2 owned the bus last
   logic [CNT_W-1:0] tenure_r;
   logic             limit_s;
   logic             owned_s;

   logic [SEL_W-1:0] owner_sel_s;
   logic             owner_rw_s;
   logic [1:0]       dec_en_s;
   logic             dec_err_s;
   logic             dec_rw_s;

   logic             grant_1_r;
   logic             grant_2_r;
   logic [1:0]       slave_en_r;
   logic             bus_rw_r;
   logic             bus_busy_r;
   logic             decode_err_r;

   // ">=" rather than "==": tenure saturates, so an owner that held the bus
   // alone past the limit must still yield as soon as the other master asks.
   assign limit_s = (tenure_r >= CNT_W'(MAX_TENURE - 1));
   assign owned_s = (state_r == GNT1) || (state_r == GNT2);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decision: free states arbitrate, owners release or get preempted.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE, TURN: begin
            next_state_s = pick_owner(busreq_1, busreq_2, last_owner_r);
         end
         GNT1: begin
            if (!busreq_1 || (busreq_2 && limit_s)) begin
               next_state_s = TURN;
            end else begin
               next_state_s = GNT1;
            end
         end
         GNT2: begin
            if (!busreq_2 || (busreq_1 && limit_s)) begin
               next_state_s = TURN;
            end else begin
               next_state_s = GNT2;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Tenure counter and last-owner memory, both updated as an owner leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tenure_r     <= {CNT_W{1'b0}};
         last_owner_r <= 1'b1;
      end else if (owned_s && (next_state_s == TURN)) begin
         tenure_r     <= {CNT_W{1'b0}};
         last_owner_r <= (state_r == GNT2);
      end else if (owned_s) begin
         if (tenure_r < CNT_W'(MAX_TENURE)) begin
            tenure_r <= tenure_r + CNT_W'(1);
         end else begin
            tenure_r <= tenure_r;
         end
      end else begin
         tenure_r <= {CNT_W{1'b0}};
      end
   end

   assign owner_sel_s = (state_r == GNT2) ? sel_2 : sel_1;
   assign owner_rw_s  = (state_r == GNT2) ? rw_2  : rw_1;

   bus_slave_decode #(
      .SEL_W (SEL_W)
   ) u_decode (
      .sel    (owner_sel_s),
      .rw     (owner_rw_s),
      .en     (dec_en_s),
      .err    (dec_err_s),
      .rw_out (dec_rw_s)
   );

   // Registered bus outputs; decode only drives the bus while a master owns it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_1_r    <= 1'b0;
         grant_2_r    <= 1'b0;
         bus_busy_r   <= 1'b0;
         slave_en_r   <= 2'b00;
         bus_rw_r     <= 1'b1;
         decode_err_r <= 1'b0;
      end else begin
         grant_1_r  <= (state_r == GNT1);
         grant_2_r  <= (state_r == GNT2);
         bus_busy_r <= owned_s;
         if (owned_s) begin
            slave_en_r   <= dec_en_s;
            bus_rw_r     <= dec_rw_s;
            decode_err_r <= dec_err_s;
         end else begin
            slave_en_r   <= 2'b00;
            bus_rw_r     <= 1'b1;
            decode_err_r <= 1'b0;
         end
      end
   end

   assign grant_1    = grant_1_r;
   assign grant_2    = grant_2_r;
   assign slave_en   = slave_en_r;
   assign bus_rw     = bus_rw_r;
   assign bus_busy   = bus_busy_r;
   assign decode_err = decode_err_r;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_2m
// Scoreboard bench: each clock edge the reference model computes the outputs
// the arbiter must show after that edge and queues them; a monitor on the
// falling edge pops and compares. The model tracks ownership as "who holds the
// bus and for how many cycles", with the outputs lagging ownership by a cycle.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_2m;

   localparam int SEL_W      = 3;
   localparam int MAX_TENURE = 16;
   localparam int CNT_W      = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             busreq_1, busreq_2, rw_1, rw_2;
   logic [SEL_W-1:0] sel_1, sel_2;
   logic             grant_1, grant_2, bus_rw, bus_busy, decode_err;
   logic [1:0]       slave_en;

   bus_arbiter_2m #(
      .SEL_W (SEL_W), .MAX_TENURE (MAX_TENURE), .CNT_W (CNT_W)
   ) dut (
      .clk (clk), .rst (rst),
      .busreq_1 (busreq_1), .busreq_2 (busreq_2),
      .rw_1 (rw_1), .rw_2 (rw_2),
      .sel_1 (sel_1), .sel_2 (sel_2),
      .grant_1 (grant_1), .grant_2 (grant_2),
      .slave_en (slave_en), .bus_rw (bus_rw),
      .bus_busy (bus_busy), .decode_err (decode_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       g1;
      logic       g2;
      logic [1:0] en;
      logic       rw;
      logic       busy;
      logic       err;
   } obs_t;

   obs_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: owner 0 = nobody, 1/2 = master; held = cycles owned.
   int m_owner = 0;
   int m_last  = 2;
   int m_held  = 0;

   function automatic obs_t reset_obs();
      obs_t o;
      o    = '0;
      o.rw = 1'b1;
      return o;
   endfunction

   task automatic model_reset();
      m_owner = 0;
      m_last  = 2;
      m_held  = 0;
   endtask

   task automatic model_edge();
      obs_t       e;
      logic [2:0] s;
      logic       mine, other;
      if (rst) begin
         e = reset_obs();
         model_reset();
      end else begin
         e = reset_obs();
         if (m_owner != 0) begin
            e.g1   = (m_owner == 1);
            e.g2   = (m_owner == 2);
            e.busy = 1'b1;
            s      = (m_owner == 1) ? sel_1 : sel_2;
            e.rw   = (m_owner == 1) ? rw_1 : rw_2;
            if (s == 3'd1)      e.en  = 2'b01;
            else if (s == 3'd2) e.en  = 2'b10;
            else                e.err = 1'b1;
         end
         if (m_owner == 0) begin
            if (busreq_1 && busreq_2) m_owner = (m_last == 1) ? 2 : 1;
            else if (busreq_1)        m_owner = 1;
            else if (busreq_2)        m_owner = 2;
            m_held = 0;
         end else begin
            m_held = m_held + 1;
            mine   = (m_owner == 1) ? busreq_1 : busreq_2;
            other  = (m_owner == 1) ? busreq_2 : busreq_1;
            if (!mine || (other && m_held >= MAX_TENURE)) begin
               m_last  = m_owner;
               m_owner = 0;
            end
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic hold(input logic r1, input logic r2, input int n);
      busreq_1 = r1;
      busreq_2 = r2;
      repeat (n) tick();
   endtask

   // Wait a bounded number of cycles for a grant to the given master.
   task automatic wait_for_grant(input int which, input int max_cycles);
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < max_cycles) begin
         tick();
         n++;
         seen = (which == 1) ? (grant_1 === 1'b1) : (grant_2 === 1'b1);
      end
      if (!seen) begin
         miscompares++;
         $display("FAIL wait t=%0t no grant_%0d within %0d cycles", $time, which, max_cycles);
      end
   endtask

   // Reset asserted between edges: outputs must drop before the next edge.
   task automatic mid_reset(input int cycles);
      obs_t a;
      #1;
      rst = 1'b1;
      #1;
      a = {grant_1, grant_2, slave_en, bus_rw, bus_busy, decode_err};
      if (a !== reset_obs()) begin
         miscompares++;
         $display("FAIL reset t=%0t outputs did not drop asynchronously: g1=%b g2=%b en=%b rw=%b busy=%b err=%b",
                  $time, a.g1, a.g2, a.en, a.rw, a.busy, a.err);
      end
      exp_q.delete();
      model_reset();
      exp_q.push_back(reset_obs());
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   // Monitor: compare every queued expectation on the falling edge.
   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {grant_1, grant_2, slave_en, bus_rw, bus_busy, decode_err};
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL outputs t=%0t got g1=%b g2=%b en=%b rw=%b busy=%b err=%b expected g1=%b g2=%b en=%b rw=%b busy=%b err=%b",
                        $time, a.g1, a.g2, a.en, a.rw, a.busy, a.err,
                        e.g1, e.g2, e.en, e.rw, e.busy, e.err);
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      busreq_1 = 1'b0; busreq_2 = 1'b0;
      rw_1     = 1'b0; rw_2     = 1'b0;
      sel_1    = 3'b001; sel_2  = 3'b010;
      repeat (3) tick();
      rst = 1'b0;

      // Reset mid-transfer with both requests high, then recovery.
      hold(1'b1, 1'b1, 4);
      mid_reset(2);
      hold(1'b1, 1'b1, 6);
      hold(1'b0, 1'b0, 4);

      // Single write by master 1.
      sel_1 = 3'b001; rw_1 = 1'b1;
      busreq_1 = 1'b1; busreq_2 = 1'b0;
      wait_for_grant(1, 4);
      hold(1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 4);

      // Contention straight out of reset.
      mid_reset(2);
      hold(1'b1, 1'b1, 4);
      hold(1'b0, 1'b1, 6);
      hold(1'b0, 1'b0, 3);

      // Preemption of a long master-1 transfer.
      sel_2 = 3'b010; rw_2 = 1'b0;
      hold(1'b1, 1'b0, 3);
      hold(1'b1, 1'b1, 40);
      hold(1'b0, 1'b0, 3);

      // Unmapped select by master 2.
      sel_2 = 3'b100;
      hold(1'b0, 1'b1, 5);
      hold(1'b0, 1'b0, 3);

      // Continuous contention: alternating full tenures.
      sel_1 = 3'b001; sel_2 = 3'b010;
      hold(1'b1, 1'b1, 100);
      hold(1'b0, 1'b0, 3);

      // Lone owner past the limit, then the other master arrives.
      hold(1'b1, 1'b0, 25);
      hold(1'b1, 1'b1, 30);
      hold(1'b0, 1'b0, 3);

      // Randomised traffic with sticky requests and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) busreq_1 = ~busreq_1;
         if ($urandom_range(0, 5) == 0) busreq_2 = ~busreq_2;
         sel_1 = SEL_W'($urandom_range(0, 7));
         sel_2 = SEL_W'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) sel_1 = 3'b001;
         if ($urandom_range(0, 1) == 0) sel_2 = 3'b010;
         rw_1 = 1'($urandom_range(0, 1));
         rw_2 = 1'($urandom_range(0, 1));
         tick();
         if ($urandom_range(0, 499) == 0) mid_reset(2);
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      if (miscompares != 0) begin
         $display("FAIL %0d miscompares", miscompares);
      end else begin
         $display("PASS");
      end
      $finish;
   end

endmodule
